// File: rtl/rob_freelist_core.sv
// rtl/rob_freelist_core.sv - 3-wide reorder buffer, completion stage and 32-entry free list
module rob_freelist_core #(
  parameter int ROB  = 5,
  parameter int PR   = 6,
  parameter int XLEN = 32,
  localparam int EW  = XLEN + 8 + 2 * PR,
  localparam int FW  = ROB + 2 * XLEN + PR + 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0][EW-1:0]      rob_in,
  output logic [2:0][ROB-1:0]     dispatch_index,
  output logic [2:0]              struct_stall,
  output logic [2:0][EW-1:0]      retire_entry,
  input  logic [2:0][FW-1:0]      fu_c_in,
  output logic [2:0][PR-1:0]      cdb_t,
  output logic [2:0][XLEN-1:0]    wb_value,
  output logic [2:0]              fu_c_stall,
  input  logic [2:0]              DispatchEN,
  output logic [2:0][PR-1:0]      FreeReg,
  output logic [2:0]              FreeRegValid,
  output logic [4:0]              Head,
  output logic [4:0]              fl_distance,
  input  logic [2:0]              RetireEN,
  input  logic [2:0][PR-1:0]      RetireReg,
  input  logic                    BPRecoverEN,
  input  logic [4:0]              BPRecoverHead
);

  localparam int DEPTH = 2 ** ROB;

  // ROB entry field positions, LSB first: target_pc, precise_state_need,
  // completed, arch_reg, Told, Tnew, valid
  localparam int E_PSN  = XLEN;
  localparam int E_CMP  = XLEN + 1;
  localparam int E_V    = XLEN + 7 + 2 * PR;

  // FU packet field positions, LSB first: rob_entry, dest_value, dest_pr,
  // target_pc, if_take_branch, valid
  localparam int F_VAL  = ROB;
  localparam int F_PR   = ROB + XLEN;
  localparam int F_PC   = ROB + XLEN + PR;
  localparam int F_BR   = ROB + 2 * XLEN + PR;
  localparam int F_V    = ROB + 2 * XLEN + PR + 1;

  function automatic logic [1:0] pop3(input logic [2:0] v);
    pop3 = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  // ---------------------------------------------------------------------
  // Completion stage
  // ---------------------------------------------------------------------
  logic [2:0]            complete_valid;
  logic [2:0]            precise_state_valid;
  logic [2:0][ROB-1:0]   complete_index;
  logic [2:0][XLEN-1:0]  complete_pc;

  // Decode FU results into ROB completion updates and CDB broadcasts
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      complete_valid[i]      = fu_c_in[i][F_V];
      precise_state_valid[i] = fu_c_in[i][F_BR];
      complete_index[i]      = fu_c_in[i][ROB-1:0];
      complete_pc[i]         = fu_c_in[i][F_PC +: XLEN];
      cdb_t[i]               = fu_c_in[i][F_V] ? fu_c_in[i][F_PR +: PR] : '0;
      wb_value[i]            = fu_c_in[i][F_VAL +: XLEN];
    end
  end

  assign fu_c_stall = 3'b000;

  // ---------------------------------------------------------------------
  // Reorder buffer
  // ---------------------------------------------------------------------
  logic [EW-1:0]         rob_mem [DEPTH];
  logic [ROB-1:0]        rob_head;
  logic [ROB-1:0]        rob_tail;
  logic [ROB:0]          rob_count;
  logic [ROB:0]          rob_space;
  logic [2:0]            disp_valid;
  logic [2:0]            disp_we;
  logic [2:0][ROB-1:0]   ret_index;
  logic [2:0][EW-1:0]    ret_raw;
  logic [2:0]            ret_ok;
  logic [1:0]            ret_cnt;
  logic [1:0]            disp_cnt;
  logic [ROB-1:0]        rob_head_next;

  assign rob_space = (ROB+1)'(DEPTH) - rob_count;

  // Dispatch slot assignment: oldest valid way takes the tail, younger
  // valid ways follow; stall thresholds depend only on free space
  always_comb begin
    for (int i = 0; i < 3; i++) disp_valid[i] = rob_in[i][E_V];
    dispatch_index[2] = rob_tail;
    dispatch_index[1] = rob_tail + ROB'(disp_valid[2]);
    dispatch_index[0] = rob_tail + ROB'(disp_valid[2]) + ROB'(disp_valid[1]);
    struct_stall[2]   = (rob_space == '0);
    struct_stall[1]   = (rob_space < (ROB+1)'(2));
    struct_stall[0]   = (rob_space < (ROB+1)'(3));
    disp_we           = disp_valid & ~struct_stall & {3{~BPRecoverEN}};
    disp_cnt          = pop3(disp_we);
  end

  // Retire window: a slot retires only behind fully completed older slots,
  // and nothing retires past an entry that needs precise-state recovery
  always_comb begin
    ret_index[2] = rob_head;
    ret_index[1] = rob_head + ROB'(1);
    ret_index[0] = rob_head + ROB'(2);
    for (int k = 0; k < 3; k++) ret_raw[k] = rob_mem[ret_index[k]];
    ret_ok[2] = ret_raw[2][E_V] & ret_raw[2][E_CMP];
    ret_ok[1] = ret_ok[2] & ~ret_raw[2][E_PSN] & ret_raw[1][E_V] & ret_raw[1][E_CMP];
    ret_ok[0] = ret_ok[1] & ~ret_raw[1][E_PSN] & ret_raw[0][E_V] & ret_raw[0][E_CMP];
    for (int k = 0; k < 3; k++) retire_entry[k] = {ret_ok[k], ret_raw[k][EW-2:0]};
    ret_cnt       = pop3(ret_ok);
    rob_head_next = rob_head + ROB'(ret_cnt);
  end

  // ROB state: retire frees, dispatch writes, completion marks; flush empties
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rob_mem[i] <= '0;
      rob_head  <= '0;
      rob_tail  <= '0;
      rob_count <= '0;
    end else begin
      rob_head <= rob_head_next;
      if (BPRecoverEN) begin
        for (int i = 0; i < DEPTH; i++) rob_mem[i] <= '0;
        rob_tail  <= rob_head_next;
        rob_count <= '0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (ret_ok[k]) rob_mem[ret_index[k]] <= '0;
        end
        for (int i = 2; i >= 0; i--) begin
          if (disp_we[i]) rob_mem[dispatch_index[i]] <= rob_in[i];
        end
        for (int i = 0; i < 3; i++) begin
          if (complete_valid[i]) begin
            rob_mem[complete_index[i]][E_CMP] <= 1'b1;
            if (precise_state_valid[i]) begin
              rob_mem[complete_index[i]][E_PSN]     <= 1'b1;
              rob_mem[complete_index[i]][XLEN-1:0]  <= complete_pc[i];
            end
          end
        end
        rob_tail  <= rob_tail + ROB'(disp_cnt);
        rob_count <= rob_count + (ROB+1)'(disp_cnt) - (ROB+1)'(ret_cnt);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Physical-register free list
  // ---------------------------------------------------------------------
  logic [PR-1:0]         fl_mem [32];
  logic [4:0]            fl_head;
  logic [4:0]            fl_tail;
  logic [5:0]            fl_count;
  logic [2:0][4:0]       push_index;
  logic [1:0]            pop_cnt;
  logic [1:0]            push_cnt;
  logic [4:0]            fl_tail_next;
  logic [4:0]            fl_recover_gap;

  // Offered free registers, availability, and push/pop bookkeeping
  always_comb begin
    FreeReg[2]      = fl_mem[fl_head];
    FreeReg[1]      = fl_mem[fl_head + 5'd1];
    FreeReg[0]      = fl_mem[fl_head + 5'd2];
    FreeRegValid[2] = (fl_count != 6'd0);
    FreeRegValid[1] = (fl_count >= 6'd2);
    FreeRegValid[0] = (fl_count >= 6'd3);
    pop_cnt         = pop3(DispatchEN & FreeRegValid);
    push_cnt        = pop3(RetireEN);
    push_index[2]   = fl_tail;
    push_index[1]   = fl_tail + 5'(RetireEN[2]);
    push_index[0]   = fl_tail + 5'(RetireEN[2]) + 5'(RetireEN[1]);
    fl_tail_next    = fl_tail + 5'(push_cnt);
    fl_recover_gap  = fl_tail_next - BPRecoverHead;
  end

  assign Head        = fl_head;
  assign fl_distance = fl_tail - fl_head;

  // Free-list state: returned tags append at the tail; recovery rewinds head
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) fl_mem[i] <= PR'(32 + i);
      fl_head  <= '0;
      fl_tail  <= '0;
      fl_count <= 6'd32;
    end else begin
      for (int i = 2; i >= 0; i--) begin
        if (RetireEN[i]) fl_mem[push_index[i]] <= RetireReg[i];
      end
      fl_tail <= fl_tail_next;
      if (BPRecoverEN) begin
        fl_head  <= BPRecoverHead;
        fl_count <= (fl_recover_gap == 5'd0) ? 6'd32 : {1'b0, fl_recover_gap};
      end else begin
        fl_head  <= fl_head + 5'(pop_cnt);
        fl_count <= fl_count + 6'(push_cnt) - 6'(pop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rob_freelist_core.sv
// tb/tb_rob_freelist_core.sv - directed self-checking bench for rob_freelist_core
module tb_rob_freelist_core;

  logic              clock;
  logic              reset;
  logic [2:0][51:0]  rob_in;
  logic [2:0][4:0]   dispatch_index;
  logic [2:0]        struct_stall;
  logic [2:0][51:0]  retire_entry;
  logic [2:0][76:0]  fu_c_in;
  logic [2:0][5:0]   cdb_t;
  logic [2:0][31:0]  wb_value;
  logic [2:0]        fu_c_stall;
  logic [2:0]        DispatchEN;
  logic [2:0][5:0]   FreeReg;
  logic [2:0]        FreeRegValid;
  logic [4:0]        Head;
  logic [4:0]        fl_distance;
  logic [2:0]        RetireEN;
  logic [2:0][5:0]   RetireReg;
  logic              BPRecoverEN;
  logic [4:0]        BPRecoverHead;

  int errors = 0;
  int checks = 0;

  rob_freelist_core dut (
    .clock(clock), .reset(reset), .rob_in(rob_in), .dispatch_index(dispatch_index),
    .struct_stall(struct_stall), .retire_entry(retire_entry), .fu_c_in(fu_c_in),
    .cdb_t(cdb_t), .wb_value(wb_value), .fu_c_stall(fu_c_stall), .DispatchEN(DispatchEN),
    .FreeReg(FreeReg), .FreeRegValid(FreeRegValid), .Head(Head), .fl_distance(fl_distance),
    .RetireEN(RetireEN), .RetireReg(RetireReg), .BPRecoverEN(BPRecoverEN),
    .BPRecoverHead(BPRecoverHead)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [51:0] mk_entry(input logic [5:0] tnew, input logic [5:0] told,
                                           input logic [4:0] arch);
    return {1'b1, tnew, told, arch, 2'b00, 32'd0};
  endfunction

  function automatic logic [76:0] mk_fu(input logic v, input logic br, input logic [31:0] pc,
                                        input logic [5:0] pr, input logic [31:0] val,
                                        input logic [4:0] idx);
    return {v, br, pc, pr, val, idx};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rob_in = '0; fu_c_in = '0; DispatchEN = '0; RetireEN = '0; RetireReg = '0;
    BPRecoverEN = 1'b0; BPRecoverHead = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++; if (struct_stall !== 3'b000) begin errors++; $display("FAIL reset_stall got=%b exp=000", struct_stall); end
    checks++; if ({retire_entry[2][51], retire_entry[1][51], retire_entry[0][51]} !== 3'b000) begin errors++; $display("FAIL reset_retire_valid got=%b exp=000", {retire_entry[2][51], retire_entry[1][51], retire_entry[0][51]}); end
    checks++; if (fl_distance !== 5'd0) begin errors++; $display("FAIL reset_distance got=%0d exp=0", fl_distance); end
    checks++; if (Head !== 5'd0) begin errors++; $display("FAIL reset_head got=%0d exp=0", Head); end
    checks++; if (FreeReg !== {6'd32, 6'd33, 6'd34}) begin errors++; $display("FAIL reset_freereg got=%h exp=%h", FreeReg, {6'd32, 6'd33, 6'd34}); end
    checks++; if (FreeRegValid !== 3'b111) begin errors++; $display("FAIL reset_freevalid got=%b exp=111", FreeRegValid); end
    checks++; if (dispatch_index !== 15'd0) begin errors++; $display("FAIL reset_dispatch_index got=%h exp=0", dispatch_index); end
    checks++; if (fu_c_stall !== 3'b000) begin errors++; $display("FAIL reset_fu_stall got=%b exp=000", fu_c_stall); end
  endtask

  task automatic test_dispatch();
    rob_in[2] = mk_entry(6'd32, 6'd1, 5'd1);
    rob_in[1] = mk_entry(6'd33, 6'd2, 5'd2);
    rob_in[0] = mk_entry(6'd34, 6'd3, 5'd3);
    DispatchEN = 3'b111;
    #1;
    checks++; if (dispatch_index !== {5'd0, 5'd1, 5'd2}) begin errors++; $display("FAIL disp_index got=%h exp=%h", dispatch_index, {5'd0, 5'd1, 5'd2}); end
    step();
    clear_inputs();
    #1;
    checks++; if (dispatch_index[2] !== 5'd3) begin errors++; $display("FAIL disp_tail got=%0d exp=3", dispatch_index[2]); end
    checks++; if (Head !== 5'd3) begin errors++; $display("FAIL disp_head got=%0d exp=3", Head); end
    checks++; if (FreeReg !== {6'd35, 6'd36, 6'd37}) begin errors++; $display("FAIL disp_freereg got=%h exp=%h", FreeReg, {6'd35, 6'd36, 6'd37}); end
    checks++; if (fl_distance !== 5'd29) begin errors++; $display("FAIL disp_distance got=%0d exp=29", fl_distance); end
    checks++; if (retire_entry[2][51] !== 1'b0) begin errors++; $display("FAIL disp_not_retirable got=%b exp=0", retire_entry[2][51]); end
  endtask

  task automatic test_complete();
    fu_c_in[0] = mk_fu(1'b1, 1'b0, 32'd0,  6'd32, 32'd100, 5'd0);
    fu_c_in[1] = mk_fu(1'b1, 1'b1, 32'd32, 6'd33, 32'd101, 5'd1);
    fu_c_in[2] = mk_fu(1'b1, 1'b0, 32'd0,  6'd34, 32'd102, 5'd2);
    #1;
    checks++; if (cdb_t !== {6'd34, 6'd33, 6'd32}) begin errors++; $display("FAIL cmp_cdb got=%h exp=%h", cdb_t, {6'd34, 6'd33, 6'd32}); end
    checks++; if (wb_value !== {32'd102, 32'd101, 32'd100}) begin errors++; $display("FAIL cmp_wb got=%h", wb_value); end
    checks++; if (retire_entry[2][51] !== 1'b0) begin errors++; $display("FAIL cmp_same_cycle got=%b exp=0", retire_entry[2][51]); end
    step();
    clear_inputs();
    fu_c_in[0] = mk_fu(1'b0, 1'b0, 32'd0, 6'd9, 32'd0, 5'd0);
    #1;
    checks++; if (cdb_t !== 18'd0) begin errors++; $display("FAIL cmp_cdb_invalid got=%h exp=0", cdb_t); end
    checks++; if ({retire_entry[2][51], retire_entry[2][50:45], retire_entry[2][44:39]} !== {1'b1, 6'd32, 6'd1}) begin errors++; $display("FAIL ret_slot2 got=%h", retire_entry[2]); end
    checks++; if ({retire_entry[1][51], retire_entry[1][50:45], retire_entry[1][32], retire_entry[1][31:0]} !== {1'b1, 6'd33, 1'b1, 32'd32}) begin errors++; $display("FAIL ret_slot1_branch got=%h", retire_entry[1]); end
    checks++; if (retire_entry[0][51] !== 1'b0) begin errors++; $display("FAIL ret_slot0_blocked got=%b exp=0", retire_entry[0][51]); end
    step();
    fu_c_in = '0;
    #1;
    checks++; if ({retire_entry[2][51], retire_entry[2][50:45], retire_entry[1][51]} !== {1'b1, 6'd34, 1'b0}) begin errors++; $display("FAIL ret_after_branch got=%h/%b", retire_entry[2], retire_entry[1][51]); end
    step();
    #1;
    checks++; if (retire_entry[2][51] !== 1'b0) begin errors++; $display("FAIL ret_drained got=%b exp=0", retire_entry[2][51]); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 10; c++) begin
      rob_in[2] = mk_entry(6'(c), 6'd4, 5'd4);
      rob_in[1] = mk_entry(6'(c), 6'd5, 5'd5);
      rob_in[0] = mk_entry(6'(c), 6'd6, 5'd6);
      step();
    end
    rob_in = '0;
    #1;
    checks++; if (struct_stall !== 3'b001) begin errors++; $display("FAIL fill30_stall got=%b exp=001", struct_stall); end
    checks++; if (dispatch_index[2] !== 5'd1) begin errors++; $display("FAIL fill30_tail got=%0d exp=1", dispatch_index[2]); end
    rob_in[2] = mk_entry(6'd10, 6'd7, 5'd7);
    step();
    #1;
    checks++; if (struct_stall !== 3'b011) begin errors++; $display("FAIL fill31_stall got=%b exp=011", struct_stall); end
    step();
    #1;
    checks++; if (struct_stall !== 3'b111) begin errors++; $display("FAIL full_stall got=%b exp=111", struct_stall); end
    checks++; if (dispatch_index[2] !== 5'd3) begin errors++; $display("FAIL full_tail got=%0d exp=3", dispatch_index[2]); end
    step();
    #1;
    checks++; if ({struct_stall, dispatch_index[2]} !== {3'b111, 5'd3}) begin errors++; $display("FAIL full_drop got=%b/%0d exp=111/3", struct_stall, dispatch_index[2]); end
    rob_in = '0;
  endtask

  task automatic test_flush();
    BPRecoverEN = 1'b1; BPRecoverHead = 5'd3;
    step();
    clear_inputs();
    #1;
    checks++; if ({struct_stall, Head} !== {3'b000, 5'd3}) begin errors++; $display("FAIL flush_full got=%b/%0d exp=000/3", struct_stall, Head); end
    for (int c = 0; c < 2; c++) begin
      rob_in[2] = mk_entry(6'd40, 6'd8, 5'd8);
      rob_in[1] = mk_entry(6'd41, 6'd9, 5'd9);
      rob_in[0] = mk_entry(6'd42, 6'd10, 5'd10);
      DispatchEN = 3'b111;
      step();
    end
    clear_inputs();
    #1;
    checks++; if ({dispatch_index[2], Head} !== {5'd9, 5'd9}) begin errors++; $display("FAIL six_entries got=%0d/%0d exp=9/9", dispatch_index[2], Head); end
    rob_in[2] = mk_entry(6'd50, 6'd11, 5'd11);
    rob_in[1] = mk_entry(6'd51, 6'd12, 5'd12);
    rob_in[0] = mk_entry(6'd52, 6'd13, 5'd13);
    DispatchEN = 3'b111; BPRecoverEN = 1'b1; BPRecoverHead = 5'd3;
    step();
    clear_inputs();
    fu_c_in[2] = mk_fu(1'b1, 1'b0, 32'd0, 6'd40, 32'd0, 5'd3);
    #1;
    checks++; if (dispatch_index[2] !== 5'd3) begin errors++; $display("FAIL flush_tail got=%0d exp=3", dispatch_index[2]); end
    checks++; if (Head !== 5'd3) begin errors++; $display("FAIL flush_fl_head got=%0d exp=3", Head); end
    checks++; if ({fl_distance, FreeRegValid} !== {5'd29, 3'b111}) begin errors++; $display("FAIL flush_fl_count got=%0d/%b exp=29/111", fl_distance, FreeRegValid); end
    checks++; if (FreeReg !== {6'd35, 6'd36, 6'd37}) begin errors++; $display("FAIL flush_freereg got=%h exp=%h", FreeReg, {6'd35, 6'd36, 6'd37}); end
    step();
    fu_c_in = '0;
    #1;
    checks++; if (retire_entry[2][51] !== 1'b0) begin errors++; $display("FAIL flush_invalidated got=%b exp=0", retire_entry[2][51]); end
  endtask

  task automatic test_freelist_wrap();
    RetireEN = 3'b101; RetireReg[2] = 6'd1; RetireReg[1] = 6'd7; RetireReg[0] = 6'd3;
    step();
    clear_inputs();
    #1;
    checks++; if ({fl_distance, FreeRegValid, Head} !== {5'd31, 3'b111, 5'd3}) begin errors++; $display("FAIL push2 got=%0d/%b/%0d exp=31/111/3", fl_distance, FreeRegValid, Head); end
    BPRecoverEN = 1'b1; BPRecoverHead = 5'd0;
    step();
    clear_inputs();
    #1;
    checks++; if (FreeReg !== {6'd1, 6'd3, 6'd34}) begin errors++; $display("FAIL pushed_tags got=%h exp=%h", FreeReg, {6'd1, 6'd3, 6'd34}); end
    checks++; if ({Head, fl_distance, FreeRegValid} !== {5'd0, 5'd2, 3'b110}) begin errors++; $display("FAIL recover_count2 got=%0d/%0d/%b exp=0/2/110", Head, fl_distance, FreeRegValid); end
    DispatchEN = 3'b111;
    step();
    clear_inputs();
    #1;
    checks++; if ({Head, fl_distance, FreeRegValid} !== {5'd2, 5'd0, 3'b000}) begin errors++; $display("FAIL fl_empty got=%0d/%0d/%b exp=2/0/000", Head, fl_distance, FreeRegValid); end
    DispatchEN = 3'b111; RetireEN = 3'b100; RetireReg[2] = 6'd20;
    step();
    clear_inputs();
    #1;
    checks++; if ({FreeReg[2], FreeRegValid, fl_distance, Head} !== {6'd20, 3'b100, 5'd1, 5'd2}) begin errors++; $display("FAIL back_to_back got=%0d/%b/%0d/%0d exp=20/100/1/2", FreeReg[2], FreeRegValid, fl_distance, Head); end
    BPRecoverEN = 1'b1; BPRecoverHead = 5'd3;
    step();
    clear_inputs();
    #1;
    checks++; if ({Head, fl_distance, FreeRegValid} !== {5'd3, 5'd0, 3'b111}) begin errors++; $display("FAIL recover_full got=%0d/%0d/%b exp=3/0/111", Head, fl_distance, FreeRegValid); end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_complete();
    test_fill();
    test_flush();
    test_freelist_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
